// File: rtl/jk_reg_bank_pkg.sv
// jk_pkg: shared constants for the multi-mode JK register bank.
//   MODE_W             width of the per-bank mode select
//   MODE_JK/D/T/SR     mode encodings driven on the mode input
package jk_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_JK = 2'b00;
    localparam logic [MODE_W-1:0] MODE_D  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_T  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_SR = 2'b11;

endpackage

// File: rtl/jk_reg_bank_if.sv
// jk_reg_bank_if: control/data bundle of the register bank.
//   master modport: drives enabled/mode/J/K/load/load_val/clr_err, observes Q/Qn/chg/tgl_cnt/sr_err
//   slave modport : the bank itself (reverse directions)
interface jk_reg_bank_if
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic                enabled;
    logic [MODE_W-1:0]   mode;
    logic [WIDTH-1:0]    J;
    logic [WIDTH-1:0]    K;
    logic                load;
    logic [WIDTH-1:0]    load_val;
    logic                clr_err;
    logic [WIDTH-1:0]    Q;
    logic [WIDTH-1:0]    Qn;
    logic [WIDTH-1:0]    chg;
    logic [CNT_W-1:0]    tgl_cnt;
    logic                sr_err;

    modport master (
        output enabled, mode, J, K, load, load_val, clr_err,
        input  Q, Qn, chg, tgl_cnt, sr_err
    );

    modport slave (
        input  enabled, mode, J, K, load, load_val, clr_err,
        output Q, Qn, chg, tgl_cnt, sr_err
    );
endinterface

// File: rtl/jk_reg_bank_cell.sv
// jk_cell: one bit of the register bank -- next-state logic plus its flop.
//   clk, reset      clock and synchronous active-high reset (q <= RST_BIT)
//   en, load        bit enable and parallel-load request (load wins over en)
//   ld_bit          value taken on load
//   mode            JK / D / T / SR select
//   j, k            J/D/T/S and K/R inputs
//   q               registered state
//   q_nxt           value q takes on the coming edge (ignores reset)
//   tgl_evt         this edge is a toggle event (JK 11 or T 1 while enabled)
//   sr_ill          S=R=1 seen in SR mode while enabled
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic              ld_bit,
    input  logic [MODE_W-1:0] mode,
    input  logic              j,
    input  logic              k,
    output logic              q,
    output logic              q_nxt,
    output logic              tgl_evt,
    output logic              sr_ill
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d     = q_q;
        tgl_evt = 1'b0;
        sr_ill  = 1'b0;
        if (load) begin
            q_d = ld_bit;
        end else if (en) begin
            case (mode)
                MODE_JK: begin
                    case ({j, k})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11: begin
                            q_d     = ~q_q;
                            tgl_evt = 1'b1;
                        end
                        default: q_d = q_q;
                    endcase
                end
                MODE_D: q_d = j;
                MODE_T: begin
                    if (j) begin
                        q_d     = ~q_q;
                        tgl_evt = 1'b1;
                    end
                end
                default: begin // MODE_SR
                    case ({j, k})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11:   sr_ill = 1'b1; // illegal: hold and flag
                        default: q_d = q_q;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= RST_BIT;
        else       q_q <= q_d;
    end

    assign q     = q_q;
    assign q_nxt = q_d;

endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit bank of multi-mode (JK/D/T/SR) flip-flops with
// parallel load, per-bit change pulse, saturating toggle-event counter and
// a sticky SR-illegal flag.
//   clk    rising-edge clock
//   reset  synchronous active-high reset, highest priority
//   bus    jk_reg_bank_if slave: controls/inputs in, Q/Qn/chg/tgl_cnt/sr_err out
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter int unsigned      CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    jk_reg_bank_if.slave bus
);

    localparam int unsigned PC_W  = $clog2(WIDTH + 1);
    // Sum is at least CNT_W+1 bits so an overflow is visible before the clamp.
    localparam int unsigned SUM_W = (CNT_W + 1 > PC_W + 1) ? CNT_W + 1 : PC_W + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] tgl_evt;
    logic [WIDTH-1:0] sr_ill;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell #(
            .RST_BIT (RST_VAL[gi])
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .en      (bus.enabled),
            .load    (bus.load),
            .ld_bit  (bus.load_val[gi]),
            .mode    (bus.mode),
            .j       (bus.J[gi]),
            .k       (bus.K[gi]),
            .q       (q[gi]),
            .q_nxt   (q_nxt[gi]),
            .tgl_evt (tgl_evt[gi]),
            .sr_ill  (sr_ill[gi])
        );
    end

    logic [WIDTH-1:0] chg_q,    chg_d;
    logic [CNT_W-1:0] tgl_cnt_q, tgl_cnt_d;
    logic             sr_err_q, sr_err_d;
    logic [PC_W-1:0]  pop;
    logic [SUM_W-1:0] sum;

    always_comb begin
        // Disabled bits and load both give q_nxt == q or the loaded value,
        // so this covers every non-reset case.
        chg_d = q ^ q_nxt;

        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PC_W'(tgl_evt[i]);
        end
        sum = SUM_W'(tgl_cnt_q) + SUM_W'(pop);
        if (sum > CNT_MAX) tgl_cnt_d = {CNT_W{1'b1}};
        else               tgl_cnt_d = sum[CNT_W-1:0];

        // Set wins over clear on the same edge.
        sr_err_d = sr_err_q;
        if (|sr_ill)          sr_err_d = 1'b1;
        else if (bus.clr_err) sr_err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chg_q     <= '0;
            tgl_cnt_q <= '0;
            sr_err_q  <= 1'b0;
        end else begin
            chg_q     <= chg_d;
            tgl_cnt_q <= tgl_cnt_d;
            sr_err_q  <= sr_err_d;
        end
    end

    assign bus.Q       = q;
    assign bus.Qn      = ~q;
    assign bus.chg     = chg_q;
    assign bus.tgl_cnt = tgl_cnt_q;
    assign bus.sr_err  = sr_err_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed testbench for jk_reg_bank (WIDTH=4, CNT_W=3, RST_VAL=0).
module tb_jk_reg_bank;
    import jk_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    jk_reg_bank_if #(.WIDTH(4), .CNT_W(3)) bus ();

    jk_reg_bank #(
        .WIDTH   (4),
        .CNT_W   (3),
        .RST_VAL (4'b0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] q, input logic [3:0] chg,
                           input logic [2:0] cnt, input logic err);
        chk({tag, ".Q"},      32'(bus.Q),       32'(q));
        chk({tag, ".chg"},    32'(bus.chg),     32'(chg));
        chk({tag, ".tgl"},    32'(bus.tgl_cnt), 32'(cnt));
        chk({tag, ".sr_err"}, 32'(bus.sr_err),  32'(err));
    endtask

    task automatic drive(input logic en, input logic [1:0] md, input logic [3:0] j,
                         input logic [3:0] k, input logic ld, input logic [3:0] lv,
                         input logic ce);
        bus.enabled  = en;
        bus.mode     = md;
        bus.J        = j;
        bus.K        = k;
        bus.load     = ld;
        bus.load_val = lv;
        bus.clr_err  = ce;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // 1: reset wins over load
        reset = 1'b1;
        drive(1'b1, MODE_JK, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0);
        tick();
        chk_all("reset", 4'h0, 4'h0, 3'd0, 1'b0);
        chk("reset.Qn", 32'(bus.Qn), 32'hF);
        reset = 1'b0;

        // 2: JK toggle, disabled then enabled, counter saturates
        drive(1'b0, MODE_JK, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0);
        tick();
        chk_all("dis1", 4'h0, 4'h0, 3'd0, 1'b0);
        tick();
        chk_all("dis2", 4'h0, 4'h0, 3'd0, 1'b0);
        bus.enabled = 1'b1;
        tick();
        chk_all("jk_tgl1", 4'hF, 4'hF, 3'd4, 1'b0);
        tick();
        chk_all("jk_tgl2_sat", 4'h0, 4'hF, 3'd7, 1'b0);

        // JK set/reset patterns: J=5,K=A from 0 -> 5
        drive(1'b1, MODE_JK, 4'h5, 4'hA, 1'b0, 4'h0, 1'b0);
        tick();
        chk_all("jk_setrst", 4'h5, 4'h5, 3'd7, 1'b0);

        // 3: load overrides T-mode toggling, counter unchanged
        drive(1'b1, MODE_T, 4'hF, 4'h0, 1'b1, 4'hA, 1'b0);
        tick();
        chk_all("load", 4'hA, 4'hF, 3'd7, 1'b0);

        // 4: SR mode with one illegal bit
        drive(1'b1, MODE_SR, 4'h3, 4'h5, 1'b0, 4'h0, 1'b0);
        tick();
        chk_all("sr_ill", 4'hA, 4'h0, 3'd7, 1'b1);
        drive(1'b1, MODE_SR, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        chk_all("sr_clr", 4'hA, 4'h0, 3'd7, 1'b0);
        // set wins over clear on the same edge
        drive(1'b1, MODE_SR, 4'h1, 4'h1, 1'b0, 4'h0, 1'b1);
        tick();
        chk_all("sr_setwins", 4'hA, 4'h0, 3'd7, 1'b1);
        drive(1'b1, MODE_SR, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        chk("sr_clr2", 32'(bus.sr_err), 32'h0);
        // disabled SR illegal must not flag
        drive(1'b0, MODE_SR, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0);
        tick();
        chk_all("sr_dis", 4'hA, 4'h0, 3'd7, 1'b0);

        // 5: D mode
        drive(1'b1, MODE_D, 4'h6, 4'hF, 1'b0, 4'h0, 1'b0);
        tick();
        chk_all("d_mode", 4'h6, 4'hC, 3'd7, 1'b0);
        chk("d_mode.Qn", 32'(bus.Qn), 32'h9);

        // 6: reset mid-sequence with T mode active
        drive(1'b1, MODE_T, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0);
        reset = 1'b1;
        tick();
        chk_all("rst_mid", 4'h0, 4'h0, 3'd0, 1'b0);
        reset = 1'b0;
        tick();
        chk_all("t_resume1", 4'hF, 4'hF, 3'd4, 1'b0);
        bus.J = 4'h3;
        tick();
        chk_all("t_partial", 4'hC, 4'h3, 3'd6, 1'b0);
        bus.J = 4'hF;
        tick();
        chk_all("t_sat", 4'h3, 4'hF, 3'd7, 1'b0);
        chk("t_sat.Qn", 32'(bus.Qn), 32'hC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above stalls.
    initial begin
        #100000;
        $display("FAIL timeout: sequence did not complete");
        $fatal(1, "timeout");
    end

endmodule
